// File: rtl/output_register_7seg.sv
// output_register_7seg: latches a byte from the shared bus and shows it in decimal on a
// time-multiplexed 4-digit 7-segment display (ones, tens, hundreds, sign).
module output_register_7seg #(
   parameter logic [15:0] SCAN_DIV    = 16'd50000,
   parameter bit          SIGNED_MODE = 1'b0,
   parameter bit          BLANK_LZ    = 1'b1,
   parameter bit          SEG_ACT_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       clear,
   inout  wire  [7:0] bus,
   input  logic       input_en,
   output logic [6:0] display,
   output logic [3:0] digit_sel
);
   logic [7:0]  value;
   logic [7:0]  mag;
   logic [15:0] pre;
   logic [1:0]  idx;
   logic        neg;
   logic [3:0]  hun;
   logic [3:0]  ten;
   logic [3:0]  one;
   logic [6:0]  seg_raw;
   logic [3:0]  sel_raw;

   assign bus = 8'bz;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!clear) begin
         value <= 8'h00;
         idx   <= 2'd0;
         pre   <= 16'd0;
      end else begin
         if (input_en) value <= bus;
         if (pre == SCAN_DIV - 16'd1) begin
            pre <= 16'd0;
            idx <= idx + 2'd1;
         end else begin
            pre <= pre + 16'd1;
         end
      end
   end

   // two's-complement negate of 8'h80 wraps to 8'h80, which reads as magnitude 128
   always_comb begin
      neg       = SIGNED_MODE && value[7];
      mag       = neg ? 8'(-value) : value;
      hun       = 4'(mag / 8'd100);
      ten       = 4'((mag / 8'd10) % 8'd10);
      one       = 4'(mag % 8'd10);
      seg_raw   = idx == 2'd0 ? seg7(one) :
                  idx == 2'd1 ? ((BLANK_LZ && hun == 4'd0 && ten == 4'd0) ? 7'h00 : seg7(ten)) :
                  idx == 2'd2 ? ((BLANK_LZ && hun == 4'd0) ? 7'h00 : seg7(hun)) :
                  (neg ? 7'h40 : 7'h00);
      sel_raw   = 4'b0001 << idx;
      display   = SEG_ACT_LOW ? ~seg_raw : seg_raw;
      digit_sel = SEG_ACT_LOW ? ~sel_raw : sel_raw;
   end
endmodule

// File: tb/tb_output_register_7seg.sv
// tb_output_register_7seg: table vectors, hand sequences and random stimulus against a
// decimal-arithmetic reference model, over three parameter configurations.
module tb_output_register_7seg;
   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       input_en = 1'b0;
   logic [7:0] drv = 8'h00;
   wire  [7:0] bus;
   logic [6:0] d0_disp, d1_disp, d2_disp;
   logic [3:0] d0_sel, d1_sel, d2_sel;
   int total = 0;
   int bad = 0;
   logic [7:0] m_val = 8'h00;
   int ticks = 0;
   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   typedef struct {
      int              dut;
      logic [7:0]      b;
      logic [3:0][6:0] e;
   } vec_t;
   vec_t tv [10];

   assign bus = drv;
   always #5 clk = ~clk;

   output_register_7seg #(.SCAN_DIV(16'd4), .SIGNED_MODE(1'b0), .BLANK_LZ(1'b1), .SEG_ACT_LOW(1'b0)) dut0 (
      .clk(clk), .clear(clear), .bus(bus), .input_en(input_en), .display(d0_disp), .digit_sel(d0_sel));
   output_register_7seg #(.SCAN_DIV(16'd4), .SIGNED_MODE(1'b1), .BLANK_LZ(1'b1), .SEG_ACT_LOW(1'b0)) dut1 (
      .clk(clk), .clear(clear), .bus(bus), .input_en(input_en), .display(d1_disp), .digit_sel(d1_sel));
   output_register_7seg #(.SCAN_DIV(16'd3), .SIGNED_MODE(1'b1), .BLANK_LZ(1'b0), .SEG_ACT_LOW(1'b1)) dut2 (
      .clk(clk), .clear(clear), .bus(bus), .input_en(input_en), .display(d2_disp), .digit_sel(d2_sel));

   always @(posedge clk) begin
      if (!clear) begin
         m_val <= 8'h00;
         ticks <= 0;
      end else begin
         ticks <= ticks + 1;
         if (input_en) m_val <= bus;
      end
   end

   function automatic logic [10:0] model(bit sm, bit blz, bit al, int div, logic [7:0] v, int t);
      int s;
      int m;
      int k;
      int d [3];
      logic [6:0] g;
      logic [3:0] sel;
      s = (sm && v[7]) ? int'(v) - 256 : int'(v);
      m = s < 0 ? -s : s;
      k = (t / div) % 4;
      d[0] = m % 10;
      d[1] = (m / 10) % 10;
      d[2] = m / 100;
      if (k == 3) g = s < 0 ? 7'h40 : 7'h00;
      else if (k == 2 && blz && m < 100) g = 7'h00;
      else if (k == 1 && blz && m < 10) g = 7'h00;
      else g = seg_tab[d[k]];
      sel = 4'(1 << k);
      return al ? {~g, ~sel} : {g, sel};
   endfunction

   task automatic chk(string nm, logic [10:0] got, logic [10:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("dut0", {d0_disp, d0_sel}, model(1'b0, 1'b1, 1'b0, 4, m_val, ticks));
      chk("dut1", {d1_disp, d1_sel}, model(1'b1, 1'b1, 1'b0, 4, m_val, ticks));
      chk("dut2", {d2_disp, d2_sel}, model(1'b1, 1'b0, 1'b1, 3, m_val, ticks));
      if (!$isunknown(drv)) chk("bus_undriven", {3'b0, bus}, {3'b0, drv});
   endtask

   task automatic do_reset();
      clear = 1'b0;
      input_en = 1'b0;
      @(negedge clk);
      clear = 1'b1;
   endtask

   initial begin
      tv[0] = '{0, 8'd118, {7'h00, 7'h06, 7'h06, 7'h7F}};
      tv[1] = '{0, 8'd5,   {7'h00, 7'h00, 7'h00, 7'h6D}};
      tv[2] = '{0, 8'd0,   {7'h00, 7'h00, 7'h00, 7'h3F}};
      tv[3] = '{0, 8'd255, {7'h00, 7'h5B, 7'h6D, 7'h6D}};
      tv[4] = '{0, 8'd207, {7'h00, 7'h5B, 7'h3F, 7'h07}};
      tv[5] = '{0, 8'd40,  {7'h00, 7'h00, 7'h66, 7'h3F}};
      tv[6] = '{1, 8'hFF,  {7'h40, 7'h00, 7'h00, 7'h06}};
      tv[7] = '{1, 8'h80,  {7'h40, 7'h06, 7'h5B, 7'h7F}};
      tv[8] = '{1, 8'h7F,  {7'h00, 7'h06, 7'h5B, 7'h07}};
      tv[9] = '{1, 8'hF6,  {7'h40, 7'h00, 7'h06, 7'h3F}};

      @(negedge clk);
      do_reset();
      chk("reset_disp", {4'b0, d0_disp}, {4'b0, 7'h3F});
      chk("reset_sel", {7'b0, d0_sel}, {7'b0, 4'b0001});
      check_all();

      for (int i = 0; i < 10; i++) begin
         do_reset();
         drv = tv[i].b;
         input_en = 1'b1;
         @(negedge clk);
         input_en = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            chk($sformatf("vec%0d_dig%0d", i, k),
                tv[i].dut == 0 ? {d0_disp, d0_sel} : {d1_disp, d1_sel},
                {tv[i].e[k], 4'(1 << k)});
         end
      end

      do_reset();
      for (int t = 0; t < 17; t++) begin
         chk("rotate", {7'b0, d0_sel}, {7'b0, 4'(1 << ((t / 4) % 4))});
         @(negedge clk);
      end

      do_reset();
      drv = 8'd55;
      input_en = 1'b1;
      @(negedge clk);
      input_en = 1'b0;
      drv = 8'd200;
      @(negedge clk);
      chk("hold_ones", {d0_disp, d0_sel}, {7'h6D, 4'b0001});
      check_all();
      drv = 8'd99;
      clear = 1'b0;
      input_en = 1'b1;
      @(negedge clk);
      clear = 1'b1;
      input_en = 1'b0;
      chk("clear_prio", {d0_disp, d0_sel}, {7'h3F, 4'b0001});
      drv = 8'd37;
      input_en = 1'b1;
      @(negedge clk);
      input_en = 1'b0;
      drv = 8'bx;
      repeat (2) @(negedge clk);
      chk("x_bus_ignored", {d0_disp, d0_sel}, {7'h07, 4'b0001});
      check_all();

      for (int n = 0; n < 300; n++) begin
         clear = ($urandom % 25) != 0;
         input_en = ($urandom % 3) == 0;
         drv = 8'($urandom);
         @(negedge clk);
         check_all();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
